// File: rtl/pdp8_exec_mem_responder.sv
// ============================================================================
// pdp8_exec_mem_responder : 4096x12 data store for the PDP-8 exec unit port,
// fixed-latency reads, write-first bypass, post-reset clear.  Rev 1.0
// ============================================================================
`default_nettype none

module pdp8_exec_mem_responder #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 12,
   parameter int RD_LATENCY     = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_rd_valid,
   output logic                  mem_busy,
   output logic [7:0]            req_drop_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic [7:0]            drop_cnt_q, drop_cnt_d;
   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_accept;

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      drop_cnt_d = drop_cnt_q;
      mem_we     = 1'b0;
      mem_waddr  = exec_wr_addr;
      mem_wdata  = exec_wr_data;
      rd_accept  = 1'b0;

      // Write-first: a same-address write in the sampling cycle wins.
      rd_word = mem[exec_rd_addr];
      if (exec_wr_req && (exec_wr_addr == exec_rd_addr)) begin
         rd_word = exec_wr_data;
      end

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = ST_READY;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
            if ((exec_rd_req || exec_wr_req) && (drop_cnt_q != 8'hFF)) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end
         default: begin
            mem_we    = exec_wr_req;
            rd_accept = exec_rd_req;
         end
      endcase

      // Each stage loads only on a valid beat, so the last stage holds the
      // most recently returned word between responses.
      vld_d[0] = rd_accept;
      dat_d[0] = rd_accept ? rd_word : dat_q[0];
      for (int k = 1; k < RD_LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
         dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_ptr_q  <= '0;
         drop_cnt_q <= '0;
         vld_q      <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         drop_cnt_q <= drop_cnt_d;
         vld_q      <= vld_d;
         for (int k = 0; k < RD_LATENCY; k++) begin
            dat_q[k] <= dat_d[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign exec_rd_data  = dat_q[RD_LATENCY-1];
   assign exec_rd_valid = vld_q[RD_LATENCY-1];
   assign mem_busy      = reset ? (CLEAR_ON_RESET != 0) : (state_q == ST_CLEAR);
   assign req_drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pdp8_exec_mem_responder.sv
// ============================================================================
// tb_pdp8_exec_mem_responder : three latency variants driven in lockstep and
// compared each cycle against a queue-based reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pdp8_exec_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req, wr_req;
   logic [11:0] rd_addr, wr_addr, wr_data;

   logic [11:0] rd_data  [3];
   logic        rd_valid [3];
   logic        busy     [3];
   logic [7:0]  drop     [3];

   always #5 clk = ~clk;

   pdp8_exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .exec_rd_req(rd_req), .exec_rd_addr(rd_addr),
      .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
      .exec_rd_data(rd_data[0]), .exec_rd_valid(rd_valid[0]),
      .mem_busy(busy[0]), .req_drop_cnt(drop[0]));

   pdp8_exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut_l2 (
      .clk(clk), .reset(reset),
      .exec_rd_req(rd_req), .exec_rd_addr(rd_addr),
      .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
      .exec_rd_data(rd_data[1]), .exec_rd_valid(rd_valid[1]),
      .mem_busy(busy[1]), .req_drop_cnt(drop[1]));

   pdp8_exec_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(4), .CLEAR_ON_RESET(1)) u_dut_l4 (
      .clk(clk), .reset(reset),
      .exec_rd_req(rd_req), .exec_rd_addr(rd_addr),
      .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
      .exec_rd_data(rd_data[2]), .exec_rd_valid(rd_valid[2]),
      .mem_busy(busy[2]), .req_drop_cnt(drop[2]));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: word array, clear countdown, list of accepted reads.
   typedef struct {
      int          issue;
      logic [11:0] data;
   } rd_rec_t;

   int          lat [3] = '{1, 2, 4};
   logic [11:0] mem_m [4096];
   rd_rec_t     rq [$];
   logic [11:0] last_m [3];
   bit          armed = 1'b0;
   bit          busy_m;
   int          clr_left;
   int          drop_m;
   int          cyc = 0;

   task automatic model_edge();
      if (reset) begin
         armed    = 1'b1;
         busy_m   = 1'b1;
         clr_left = 4096;
         drop_m   = 0;
         rq.delete();
         for (int i = 0; i < 3; i++) last_m[i] = '0;
      end else if (armed && busy_m) begin
         if (rd_req || wr_req) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
         mem_m[4096 - clr_left] = '0;
         clr_left--;
         if (clr_left == 0) busy_m = 1'b0;
      end else if (armed) begin
         if (rd_req)
            rq.push_back('{issue: cyc,
                           data: (wr_req && wr_addr == rd_addr) ? wr_data : mem_m[rd_addr]});
         if (wr_req) mem_m[wr_addr] = wr_data;
      end
      cyc++;
   endtask

   task automatic compare();
      bit exp_v;
      for (int i = 0; i < 3; i++) begin
         exp_v = 1'b0;
         foreach (rq[j]) begin
            if (rq[j].issue + lat[i] == cyc) begin
               exp_v     = 1'b1;
               last_m[i] = rq[j].data;
            end
         end
         check($sformatf("valid_L%0d@%0d", lat[i], cyc), rd_valid[i], exp_v);
         check($sformatf("data_L%0d@%0d", lat[i], cyc), rd_data[i], last_m[i]);
         check($sformatf("busy_L%0d@%0d", lat[i], cyc), busy[i], busy_m);
         check($sformatf("drop_L%0d@%0d", lat[i], cyc), drop[i], drop_m);
      end
      while (rq.size() > 0 && rq[0].issue + 8 < cyc) void'(rq.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (armed) compare();
   endtask

   task automatic idle();
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic rand_drive(input int rd_pct, input int wr_pct);
      rd_req  = ($urandom_range(0, 99) < rd_pct);
      wr_req  = ($urandom_range(0, 99) < wr_pct);
      rd_addr = $urandom_range(0, 1) ? 12'($urandom_range(0, 7)) : 12'($urandom);
      wr_addr = $urandom_range(0, 2) == 0 ? rd_addr
              : ($urandom_range(0, 1) ? 12'($urandom_range(0, 7)) : 12'($urandom));
      wr_data = 12'($urandom);
   endtask

   // Runs until busy falls; the first n_reads cycles carry a read request.
   task automatic wait_clear(input int n_reads);
      int n = 0;
      while (busy[0] === 1'b1 && n < 5000) begin
         if (n < n_reads) begin
            rand_drive(100, 25);
         end else begin
            idle();
         end
         n++;
         tick();
      end
      idle();
      check("clear_len", n, 4096);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      tick();
      tick();
      reset = 1'b0;
      wait_clear(300);
      check("drop_saturated", drop[0], 255);

      // Preload the top word, then reset and confirm it is cleared.
      wr_req = 1'b1; wr_addr = 12'o7777; wr_data = 12'o1234;
      tick();
      idle();
      for (int i = 0; i < 100; i++) begin rand_drive(50, 50); tick(); end
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_clear(300);
      check("drop_saturated2", drop[2], 255);
      rd_req = 1'b1; rd_addr = 12'o7777;
      tick();
      idle();
      check("rd7777_L1_valid", rd_valid[0], 1);
      check("rd7777_L1_data", rd_data[0], 0);
      tick();
      check("rd7777_L2_valid", rd_valid[1], 1);
      check("rd7777_L2_data", rd_data[1], 0);
      tick(); tick();

      // Write then read next cycle.
      wr_req = 1'b1; wr_addr = 12'o0100; wr_data = 12'o5252;
      tick();
      idle();
      rd_req = 1'b1; rd_addr = 12'o0100;
      tick();
      idle();
      check("wr_rd_L1", rd_data[0], 12'o5252);
      tick();
      check("wr_rd_L2", rd_data[1], 12'o5252);
      tick(); tick(); tick();

      // Same-cycle bypass.
      rd_req = 1'b1; rd_addr = 12'o0200;
      wr_req = 1'b1; wr_addr = 12'o0200; wr_data = 12'o7001;
      tick();
      idle();
      tick();
      check("bypass_L2", rd_data[1], 12'o7001);
      tick(); tick();

      // Snapshot: write after the read's sampling edge must not leak in.
      rd_req = 1'b1; rd_addr = 12'o0200;
      tick();
      idle();
      wr_req = 1'b1; wr_addr = 12'o0200; wr_data = 12'o0003;
      tick();
      idle();
      check("snapshot_L2", rd_data[1], 12'o7001);
      tick(); tick();
      check("snapshot_L4", rd_data[2], 12'o7001);
      tick();

      // Pipelined back-to-back reads on the latency-4 variant.
      for (int a = 1; a <= 4; a++) begin
         wr_req = 1'b1; wr_addr = 12'(a); wr_data = 12'(a * 9);
         tick();
      end
      idle();
      tick();
      for (int a = 1; a <= 4; a++) begin
         rd_req = 1'b1; rd_addr = 12'(a);
         tick();
      end
      idle();
      for (int a = 1; a <= 4; a++) begin
         check($sformatf("pipe_v%0d", a), rd_valid[2], 1);
         check($sformatf("pipe_d%0d", a), rd_data[2], 12'(a * 9));
         tick();
      end
      check("pipe_end_v", rd_valid[2], 0);

      for (int i = 0; i < 1500; i++) begin rand_drive(60, 40); tick(); end
      idle();

      // Reset with reads in flight, then again mid-clear at address 0o2000.
      rd_req = 1'b1; rd_addr = 12'o0200;
      tick();
      rd_addr = 12'o0100;
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 1024; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_clear(10);

      for (int i = 0; i < 1500; i++) begin rand_drive(60, 40); tick(); end
      idle();
      for (int i = 0; i < 6; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
